callee_port_arbiter: RTL and testbench

Shares one fixed-latency, no-backpressure external callee (e.g. an adder method: valid/a/b in, result out exactly LATENCY cycles later) among NUM_REQ requesters. Requesters present FIFO-style argument queues; the arbiter grants round-robin, issues one call per cycle, and tags each call with its requester ID. Results return through an internal response FIFO to the originating requester. Issue is gated by credits so a result is never dropped while the callee cannot stall.

---
 rtl/callee_port_arbiter_pkg.sv | 29 ++
 rtl/callee_port_arbiter_rsp_fifo.sv | 43 ++++
 rtl/callee_port_arbiter.sv | 104 ++++++++++
 tb/tb_callee_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/callee_port_arbiter_pkg.sv
// Shared types and the round-robin pick for the callee port arbiter.
// Response entries are laid out with the package widths below.
package callee_port_arbiter_pkg;

   localparam int P_NUM_REQ   = 4;
   localparam int P_WIDTH     = 32;
   localparam int P_LATENCY   = 3;
   localparam int P_RSP_DEPTH = 4;
   localparam int P_ID_W      = (P_NUM_REQ <= 2) ? 1 : $clog2(P_NUM_REQ);

   typedef struct packed {
      logic [P_ID_W-1:0]  id;
      logic [P_WIDTH-1:0] result;
   } rsp_entry_t;

   // Scan from last+NUM_REQ down to last+1 so the nearest requester after last wins.
   function automatic logic [P_ID_W-1:0] onehot_rr_pick(input logic [P_NUM_REQ-1:0] req,
                                                        input logic [P_ID_W-1:0]    last);
      logic [P_ID_W-1:0] pick;
      logic [P_ID_W-1:0] idx;
      pick = last;
      for (int k = P_NUM_REQ; k >= 1; k--) begin
         idx = P_ID_W'((int'(last) + k) % P_NUM_REQ);
         if (req[idx]) pick = idx;
      end
      return pick;
   endfunction

endpackage

// File: rtl/callee_port_arbiter_rsp_fifo.sv
// Show-ahead synchronous FIFO holding tagged callee results until the owner accepts them.
module callee_port_rsp_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic
) (
   input  logic clk,
   input  logic rst,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_head,
   output logic o_empty,
   output logic o_full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   T              r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/callee_port_arbiter.sv
// Round-robin sharing of one fixed-latency callee; results are tagged and returned
// through a credit-protected response FIFO so nothing is lost without backpressure.
module callee_port_arbiter
   import callee_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = P_NUM_REQ,
   parameter int WIDTH     = P_WIDTH,
   parameter int LATENCY   = P_LATENCY,
   parameter int RSP_DEPTH = P_RSP_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_empty_in,
   input  logic [NUM_REQ*WIDTH-1:0] req_a_in,
   input  logic [NUM_REQ*WIDTH-1:0] req_b_in,
   output logic [NUM_REQ-1:0]       req_rden_out,
   output logic                     callee_valid_out,
   output logic [WIDTH-1:0]         callee_a_out,
   output logic [WIDTH-1:0]         callee_b_out,
   input  logic [WIDTH-1:0]         callee_result_in,
   output logic [NUM_REQ-1:0]       rsp_valid_out,
   output logic [WIDTH-1:0]         rsp_result_out,
   input  logic [NUM_REQ-1:0]       rsp_rdy_in
);
   localparam int ID_W = P_ID_W;
   localparam int CW   = $clog2(RSP_DEPTH + 1);

   logic [ID_W-1:0] r_last_grant;
   logic [CW-1:0]   r_credit_cnt;
   logic            r_tag_v  [LATENCY];
   logic [ID_W-1:0] r_tag_id [LATENCY];

   logic            w_issue;
   logic            w_push;
   logic            w_pop;
   logic            w_empty;
   logic            w_full;
   logic [ID_W-1:0] w_grant;
   rsp_entry_t      w_push_entry;
   rsp_entry_t      w_head;

   // Credits count in-flight calls plus queued results, so a push always finds room.
   assign w_grant = onehot_rr_pick(~req_empty_in, r_last_grant);
   assign w_issue = !rst && (|(~req_empty_in)) && (r_credit_cnt < CW'(RSP_DEPTH));

   always_comb begin
      req_rden_out     = '0;
      callee_valid_out = w_issue;
      callee_a_out     = '0;
      callee_b_out     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_issue && (w_grant == ID_W'(i))) begin
            req_rden_out[i] = 1'b1;
            callee_a_out    = req_a_in[i*WIDTH +: WIDTH];
            callee_b_out    = req_b_in[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_credit_cnt <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            r_tag_v[i]  <= 1'b0;
            r_tag_id[i] <= '0;
         end
      end else begin
         if (w_issue) r_last_grant <= w_grant;
         r_credit_cnt <= r_credit_cnt + CW'(w_issue) - CW'(w_pop);
         r_tag_v[0]   <= w_issue;
         r_tag_id[0]  <= w_grant;
         for (int i = 1; i < LATENCY; i++) begin
            r_tag_v[i]  <= r_tag_v[i-1];
            r_tag_id[i] <= r_tag_id[i-1];
         end
      end
   end

   assign w_push       = r_tag_v[LATENCY-1];
   assign w_push_entry = '{id: r_tag_id[LATENCY-1], result: callee_result_in};

   callee_port_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .T     (rsp_entry_t)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // Head-of-line delivery: only the owner of the head entry can release it.
   assign w_pop          = !w_empty && rsp_rdy_in[w_head.id];
   assign rsp_valid_out  = w_empty ? '0 : (NUM_REQ'(1) << w_head.id);
   assign rsp_result_out = w_empty ? '0 : w_head.result;

   a_no_push_when_full : assert property (@(posedge clk) disable iff (rst) w_push |-> !w_full);

endmodule

// File: tb/tb_callee_port_arbiter.sv
// Directed bench for callee_port_arbiter with an adder callee model and per-requester queues.
module tb_callee_port_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req_empty_in;
  logic [N*W-1:0]   req_a_in;
  logic [N*W-1:0]   req_b_in;
  logic [N-1:0]     req_rden_out;
  logic             callee_valid_out;
  logic [W-1:0]     callee_a_out;
  logic [W-1:0]     callee_b_out;
  logic [W-1:0]     callee_result_in;
  logic [N-1:0]     rsp_valid_out;
  logic [W-1:0]     rsp_result_out;
  logic [N-1:0]     rsp_rdy_in;

  callee_port_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .req_empty_in     (req_empty_in),
    .req_a_in         (req_a_in),
    .req_b_in         (req_b_in),
    .req_rden_out     (req_rden_out),
    .callee_valid_out (callee_valid_out),
    .callee_a_out     (callee_a_out),
    .callee_b_out     (callee_b_out),
    .callee_result_in (callee_result_in),
    .rsp_valid_out    (rsp_valid_out),
    .rsp_result_out   (rsp_result_out),
    .rsp_rdy_in       (rsp_rdy_in)
  );

  // callee model: a+b returned L cycles after issue, ignores reset like a real callee
  logic [W-1:0] cal_r [L];
  always @(posedge clk) begin
    cal_r[0] <= callee_a_out + callee_b_out;
    for (int i = 1; i < L; i++) cal_r[i] <= cal_r[i-1];
  end
  assign callee_result_in = cal_r[L-1];

  // requester argument queues
  logic [W-1:0] qa [N][16];
  logic [W-1:0] qb [N][16];
  int           q_hd [N];
  int           q_tl [N];

  logic [N-1:0] rdy_drv;
  logic         rst_drv;
  int           n_checks;
  int           n_fail;

  logic [N-1:0] obs_rden, obs_rspv;
  logic         obs_cv;
  logic [W-1:0] obs_a, obs_b, obs_res, exp_a, exp_b;

  // scoreboard of results in expected delivery order
  logic [W-1:0] exp_q [$];

  task automatic push_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    qa[r][q_tl[r] % 16] = a;
    qb[r][q_tl[r] % 16] = b;
    q_tl[r]++;
  endtask

  // one cycle: drive at negedge, sample #1 later, pop the model queue that was read
  task automatic step();
    @(negedge clk);
    rst        = rst_drv;
    rsp_rdy_in = rdy_drv;
    for (int i = 0; i < N; i++) begin
      req_empty_in[i]      = (q_hd[i] == q_tl[i]);
      req_a_in[i*W +: W]   = qa[i][q_hd[i] % 16];
      req_b_in[i*W +: W]   = qb[i][q_hd[i] % 16];
    end
    #1;
    obs_rden = req_rden_out;
    obs_cv   = callee_valid_out;
    obs_a    = callee_a_out;
    obs_b    = callee_b_out;
    obs_rspv = rsp_valid_out;
    obs_res  = rsp_result_out;
    exp_a    = '0;
    exp_b    = '0;
    for (int i = 0; i < N; i++) begin
      if (obs_rden[i] && (q_hd[i] != q_tl[i])) begin
        exp_a = qa[i][q_hd[i] % 16];
        exp_b = qb[i][q_hd[i] % 16];
        q_hd[i]++;
      end
    end
  endtask

  task automatic test_reset();
    rst_drv = 1'b1;
    rdy_drv = '1;
    push_req(2, 32'd1, 32'd2);
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (obs_rden !== '0 || obs_cv !== 1'b0) begin
        n_fail++; $display("FAIL reset_issue c=%0d rden=%b cv=%b required 0000/0", c, obs_rden, obs_cv);
      end
      n_checks++;
      if (obs_a !== '0 || obs_b !== '0) begin
        n_fail++; $display("FAIL reset_args c=%0d a=%0d b=%0d required 0/0", c, obs_a, obs_b);
      end
      n_checks++;
      if (obs_rspv !== '0 || obs_res !== '0) begin
        n_fail++; $display("FAIL reset_rsp c=%0d rspv=%b res=%0d required 0000/0", c, obs_rspv, obs_res);
      end
    end
    for (int i = 0; i < N; i++) q_hd[i] = q_tl[i];
    rst_drv = 1'b0;
  endtask

  task automatic test_fairness();
    int tg [20];
    int eg, er;
    logic [N-1:0] e_rden, e_rsp;
    logic [W-1:0] e_res;
    tg = '{0, 1, 2, 3, -1, 0, 1, 2, 3, -1, 0, 1, 2, 3, -1, -1, -1, -1, -1, -1};
    rdy_drv = '1;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 3; k++) push_req(r, W'(r * 16 + k + 1), W'(100 * (k + 1)));
    for (int c = 0; c < 20; c++) begin
      step();
      eg     = tg[c];
      er     = (c >= 4) ? tg[c-4] : -1;
      e_rden = (eg < 0) ? '0 : (N'(1) << eg);
      e_rsp  = (er < 0) ? '0 : (N'(1) << er);
      e_res  = (er >= 0 && exp_q.size() != 0) ? exp_q[0] : '0;
      n_checks++;
      if (obs_rden !== e_rden || obs_cv !== (eg >= 0)) begin
        n_fail++; $display("FAIL fair_grant c=%0d rden=%b cv=%b required %b", c, obs_rden, obs_cv, e_rden);
      end
      n_checks++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_fail++; $display("FAIL fair_args c=%0d a=%0d b=%0d required %0d/%0d", c, obs_a, obs_b, exp_a, exp_b);
      end
      n_checks++;
      if (obs_rspv !== e_rsp || obs_res !== e_res) begin
        n_fail++; $display("FAIL fair_rsp c=%0d rspv=%b res=%0d required %b/%0d", c, obs_rspv, obs_res, e_rsp, e_res);
      end
      if (er >= 0 && rdy_drv[er] && exp_q.size() != 0) void'(exp_q.pop_front());
      if (obs_cv) exp_q.push_back(exp_a + exp_b);
    end
  endtask

  task automatic test_backpressure();
    int tg [19];
    int tr [19];
    int eg, er;
    logic [N-1:0] e_rden, e_rsp;
    logic [W-1:0] e_res;
    tg = '{0, 2, 0, 2, -1, -1, -1, -1, -1, -1, -1, 0, 2, -1, -1, -1, -1, -1, -1};
    tr = '{-1, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, -1, 0, 2, -1, -1};
    for (int k = 0; k < 3; k++) begin
      push_req(0, W'(200 + k), 32'd1);
      push_req(2, W'(300 + k), 32'd2);
    end
    for (int c = 0; c < 19; c++) begin
      rdy_drv = (c < 10) ? '0 : '1;
      step();
      eg     = tg[c];
      er     = tr[c];
      e_rden = (eg < 0) ? '0 : (N'(1) << eg);
      e_rsp  = (er < 0) ? '0 : (N'(1) << er);
      e_res  = (er >= 0 && exp_q.size() != 0) ? exp_q[0] : '0;
      n_checks++;
      if (obs_rden !== e_rden || obs_cv !== (eg >= 0)) begin
        n_fail++; $display("FAIL bp_grant c=%0d rden=%b cv=%b required %b", c, obs_rden, obs_cv, e_rden);
      end
      n_checks++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_fail++; $display("FAIL bp_args c=%0d a=%0d b=%0d required %0d/%0d", c, obs_a, obs_b, exp_a, exp_b);
      end
      n_checks++;
      if (obs_rspv !== e_rsp || obs_res !== e_res) begin
        n_fail++; $display("FAIL bp_rsp c=%0d rspv=%b res=%0d required %b/%0d", c, obs_rspv, obs_res, e_rsp, e_res);
      end
      if (er >= 0 && rdy_drv[er] && exp_q.size() != 0) void'(exp_q.pop_front());
      if (obs_cv) exp_q.push_back(exp_a + exp_b);
    end
  endtask

  task automatic test_hol();
    int tg [11];
    int tr [11];
    int eg, er;
    logic [N-1:0] e_rden, e_rsp;
    logic [W-1:0] e_res;
    tg = '{2, 0, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    tr = '{-1, -1, -1, -1, 2, 2, 2, 2, 2, 0, -1};
    for (int c = 0; c < 11; c++) begin
      if (c == 0) push_req(2, 32'd40, 32'd2);
      if (c == 1) push_req(0, 32'd10, 32'd3);
      rdy_drv = (c < 8) ? 4'b0001 : 4'b0101;
      step();
      eg     = tg[c];
      er     = tr[c];
      e_rden = (eg < 0) ? '0 : (N'(1) << eg);
      e_rsp  = (er < 0) ? '0 : (N'(1) << er);
      e_res  = (er >= 0 && exp_q.size() != 0) ? exp_q[0] : '0;
      n_checks++;
      if (obs_rden !== e_rden || obs_cv !== (eg >= 0)) begin
        n_fail++; $display("FAIL hol_grant c=%0d rden=%b cv=%b required %b", c, obs_rden, obs_cv, e_rden);
      end
      n_checks++;
      if (obs_rspv !== e_rsp || obs_res !== e_res) begin
        n_fail++; $display("FAIL hol_rsp c=%0d rspv=%b res=%0d required %b/%0d", c, obs_rspv, obs_res, e_rsp, e_res);
      end
      if (er >= 0 && rdy_drv[er] && exp_q.size() != 0) void'(exp_q.pop_front());
      if (obs_cv) exp_q.push_back(exp_a + exp_b);
    end
  endtask

  task automatic test_single();
    rdy_drv = '1;
    push_req(1, 32'd5, 32'd7);
    for (int c = 0; c < 7; c++) begin
      step();
      n_checks++;
      if (obs_rden !== ((c == 0) ? 4'b0010 : 4'b0000) || obs_cv !== (c == 0)) begin
        n_fail++; $display("FAIL single_issue c=%0d rden=%b cv=%b", c, obs_rden, obs_cv);
      end
      n_checks++;
      if (obs_a !== ((c == 0) ? 32'd5 : 32'd0) || obs_b !== ((c == 0) ? 32'd7 : 32'd0)) begin
        n_fail++; $display("FAIL single_args c=%0d a=%0d b=%0d", c, obs_a, obs_b);
      end
      n_checks++;
      if (obs_rspv !== ((c == 4) ? 4'b0010 : 4'b0000) || obs_res !== ((c == 4) ? 32'd12 : 32'd0)) begin
        n_fail++; $display("FAIL single_rsp c=%0d rspv=%b res=%0d required %b/%0d", c, obs_rspv, obs_res,
                           (c == 4) ? 4'b0010 : 4'b0000, (c == 4) ? 12 : 0);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int tg [12];
    int tr [12];
    int eg, er;
    logic [N-1:0] e_rden, e_rsp;
    logic [W-1:0] e_res;
    tg = '{3, 1, -1, -1, 0, 2, 0, 2, -1, -1, -1, -1};
    tr = '{-1, -1, -1, -1, -1, -1, -1, -1, 0, 0, 0, 0};
    rdy_drv = '1;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) push_req(3, 32'd9, 32'd9);
      if (c == 1) push_req(1, 32'd7, 32'd8);
      if (c == 2) begin
        rst_drv = 1'b1;
        exp_q.delete();
      end
      if (c == 4) begin
        rst_drv = 1'b0;
        rdy_drv = '0;
        for (int k = 0; k < 3; k++) begin
          push_req(0, W'(500 + k), 32'd5);
          push_req(2, W'(600 + k), 32'd6);
        end
      end
      step();
      eg     = tg[c];
      er     = tr[c];
      e_rden = (eg < 0) ? '0 : (N'(1) << eg);
      e_rsp  = (er < 0) ? '0 : (N'(1) << er);
      e_res  = (er >= 0 && exp_q.size() != 0) ? exp_q[0] : '0;
      n_checks++;
      if (obs_rden !== e_rden || obs_cv !== (eg >= 0)) begin
        n_fail++; $display("FAIL midrst_grant c=%0d rden=%b cv=%b required %b", c, obs_rden, obs_cv, e_rden);
      end
      n_checks++;
      if (obs_rspv !== e_rsp || obs_res !== e_res) begin
        n_fail++; $display("FAIL midrst_rsp c=%0d rspv=%b res=%0d required %b/%0d", c, obs_rspv, obs_res, e_rsp, e_res);
      end
      if (er >= 0 && rdy_drv[er] && exp_q.size() != 0) void'(exp_q.pop_front());
      if (obs_cv) exp_q.push_back(exp_a + exp_b);
    end
  endtask

  initial begin
    rst          = 1'b1;
    rst_drv      = 1'b1;
    rdy_drv      = '0;
    rsp_rdy_in   = '0;
    req_empty_in = '1;
    req_a_in     = '0;
    req_b_in     = '0;
    n_checks     = 0;
    n_fail       = 0;
    for (int i = 0; i < N; i++) begin
      q_hd[i] = 0;
      q_tl[i] = 0;
      for (int k = 0; k < 16; k++) begin
        qa[i][k] = '0;
        qb[i][k] = '0;
      end
    end
    test_reset();
    test_fairness();
    test_backpressure();
    test_hol();
    test_single();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
